// File: rtl/mac_word_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mac_word_feeder
// Purpose  : Source-side sequencer for the byte-serial MAC datapath.
//            - Reads paired attribute/coefficient words from two synchronous
//              RAMs that share one address.
//            - Holds each word pair on inputattr/inputcoeff for one 4-cycle
//              frame.
//            - Samples the MAC accumulator once per word at a fixed frame
//              phase and offers the result on a 1-entry valid/ready register.
//            - Keeps a running total of every captured result.
// Ports    : clk, rst_n           - clock, synchronous active-low reset
//            start, base_addr,
//            n_words             - job request (honoured only when idle)
//            ram_en, ram_addr    - shared read strobe/address to both RAMs
//            attr_rdata,
//            coeff_rdata         - RAM data, valid 1 cycle after ram_en
//            inputattr,
//            inputcoeff          - word pair presented to the MAC
//            mac_acc             - MAC accumulator (20 bits)
//            res_data, res_valid,
//            res_ready           - per-word result handshake
//            total               - running sum of captured results
//            busy, done          - job status / one-cycle end-of-job pulse
//            overflow            - sticky: a result was overwritten unread
// Revision : 1.0 - initial release
// ============================================================================
module mac_word_feeder #(
    parameter int ATTR_WIDTH      = 24,
    parameter int RAM1_DATA_WIDTH = 24,
    parameter int ADDR_WIDTH      = 10,
    parameter int TOTAL_WIDTH     = 28,
    parameter int CAP_PHASE       = 3,
    parameter int RES_LAG         = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH-1:0]      n_words,
    output logic                       ram_en,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    input  logic [ATTR_WIDTH-1:0]      attr_rdata,
    input  logic [RAM1_DATA_WIDTH-1:0] coeff_rdata,
    output logic [ATTR_WIDTH-1:0]      inputattr,
    output logic [RAM1_DATA_WIDTH-1:0] inputcoeff,
    input  logic [19:0]                mac_acc,
    output logic [19:0]                res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TOTAL_WIDTH-1:0]     total,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    // The frame counter keeps running through DRAIN, so it needs headroom
    // beyond n_words for up to three extra frames.
    localparam int                    c_frame_w   = ADDR_WIDTH + 2;
    localparam logic [1:0]            c_cap_phase = 2'(CAP_PHASE);
    localparam logic [c_frame_w-1:0]  c_res_lag   = c_frame_w'(RES_LAG);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic [ADDR_WIDTH-1:0]        r_base;
    logic [ADDR_WIDTH-1:0]        r_n;
    logic [1:0]                   r_phase;
    logic [c_frame_w-1:0]         r_frame;
    logic [ADDR_WIDTH-1:0]        r_cap_cnt;
    logic [ATTR_WIDTH-1:0]        r_attr;
    logic [RAM1_DATA_WIDTH-1:0]   r_coeff;
    logic [19:0]                  r_res_data;
    logic                         r_res_valid;
    logic [TOTAL_WIDTH-1:0]       r_total;
    logic                         r_done;
    logic                         r_overflow;

    logic                         w_ram_en;
    logic [ADDR_WIDTH-1:0]        w_ram_addr;
    logic                         w_start_job;
    logic                         w_load_word;
    logic                         w_load_zero;
    logic                         w_finish;
    logic                         w_capture;
    logic                         w_more;
    logic                         w_last_frame;
    logic                         w_last_cap;
    logic                         w_accept;
    logic [c_frame_w-1:0]         w_n_ext;
    logic [c_frame_w-1:0]         w_frame_inc;

    assign w_n_ext      = {2'b00, r_n};
    assign w_frame_inc  = r_frame + c_frame_w'(1);
    // Another word exists after the one currently on the MAC inputs.
    assign w_more       = (w_frame_inc < w_n_ext);
    assign w_last_frame = (w_frame_inc == w_n_ext);
    assign w_last_cap   = ((r_cap_cnt + ADDR_WIDTH'(1)) == r_n);
    assign w_accept     = r_res_valid & res_ready;

    // Result of word k appears RES_LAG frames after word k was presented;
    // the counter check stops captures once all n results are in.
    assign w_capture = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                       (r_phase == c_cap_phase) &&
                       (r_frame >= c_res_lag) &&
                       (r_cap_cnt < r_n);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        w_ram_addr  = '0;
        w_start_job = 1'b0;
        w_load_word = 1'b0;
        w_load_zero = 1'b0;
        w_finish    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_job = 1'b1;
                    if (n_words != '0) begin
                        w_state_nxt = S_PRIME;
                    end
                end
            end

            // PRIME reuses r_phase as its two-cycle counter: phase 0 issues
            // the first read, phase 1 registers the returned data.
            S_PRIME: begin
                if (r_phase == 2'd0) begin
                    w_ram_en   = 1'b1;
                    w_ram_addr = r_base;
                end else begin
                    w_load_word = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end

            S_STREAM: begin
                if ((r_phase == 2'd2) && w_more) begin
                    w_ram_en   = 1'b1;
                    w_ram_addr = r_base + r_frame[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                end
                if (r_phase == 2'd3) begin
                    w_load_word = 1'b1;
                    w_load_zero = ~w_more;
                    if (w_last_frame) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (w_capture && w_last_cap) begin
                    w_state_nxt = S_FLUSH;
                end
            end

            S_FLUSH: begin
                if (!r_res_valid) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_n         <= '0;
            r_phase     <= '0;
            r_frame     <= '0;
            r_cap_cnt   <= '0;
            r_attr      <= '0;
            r_coeff     <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_total     <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= w_finish;

            if (w_start_job) begin
                r_base     <= base_addr;
                r_n        <= n_words;
                r_total    <= '0;
                r_overflow <= 1'b0;
                r_phase    <= '0;
                r_frame    <= '0;
                r_cap_cnt  <= '0;
                // Empty job: nothing to fetch, report completion directly.
                if (n_words == '0) begin
                    r_done <= 1'b1;
                end
            end

            if (r_state == S_PRIME) begin
                // 0 -> 1, then 1 -> 0 so STREAM starts at phase 0.
                r_phase <= {1'b0, ~r_phase[0]};
            end else if ((r_state == S_STREAM) || (r_state == S_DRAIN)) begin
                r_phase <= r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    r_frame <= w_frame_inc;
                end
            end

            if (w_load_word) begin
                r_attr  <= w_load_zero ? '0 : attr_rdata;
                r_coeff <= w_load_zero ? '0 : coeff_rdata;
            end

            // A capture always wins the output register; it counts as lost
            // only if the previous result is still pending and not taken.
            if (w_capture) begin
                r_res_data  <= mac_acc;
                r_res_valid <= 1'b1;
                r_total     <= r_total + TOTAL_WIDTH'(mac_acc);
                r_cap_cnt   <= r_cap_cnt + ADDR_WIDTH'(1);
                if (r_res_valid && !res_ready) begin
                    r_overflow <= 1'b1;
                end
            end else if (w_accept) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign ram_en     = w_ram_en;
    assign ram_addr   = w_ram_addr;
    assign inputattr  = r_attr;
    assign inputcoeff = r_coeff;
    assign res_data   = r_res_data;
    assign res_valid  = r_res_valid;
    assign total      = r_total;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mac_word_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_word_feeder
// Purpose  : Directed self-checking bench for mac_word_feeder. Models the two
//            synchronous RAMs (data = tag | address) and a MAC accumulator
//            whose value at each capture slot comes from a per-job table.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mac_word_feeder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] n_words = '0;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [23:0]   attr_rdata = '0;
    logic [23:0]   coeff_rdata = '0;
    logic [23:0]   inputattr;
    logic [23:0]   inputcoeff;
    logic [19:0]   mac_acc = '0;
    logic [19:0]   res_data;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [27:0]   total;
    logic          busy;
    logic          done;
    logic          overflow;

    mac_word_feeder #(
        .ATTR_WIDTH     (24),
        .RAM1_DATA_WIDTH(24),
        .ADDR_WIDTH     (AW),
        .TOTAL_WIDTH    (28),
        .CAP_PHASE      (3),
        .RES_LAG        (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .n_words    (n_words),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .attr_rdata (attr_rdata),
        .coeff_rdata(coeff_rdata),
        .inputattr  (inputattr),
        .inputcoeff (inputcoeff),
        .mac_acc    (mac_acc),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .total      (total),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int job_s = -1000;

    logic [19:0] cap_val [0:7];
    logic [31:0] addr_q[$];
    logic [31:0] acc_q[$];
    logic [47:0] word_q[$];
    int          valid_rise = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_acc_cyc = 0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAMs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (ram_en) begin
            attr_rdata  <= 24'hA00000 | {14'd0, ram_addr};
            coeff_rdata <= 24'hC00000 | {14'd0, ram_addr};
        end
    end

    // MAC model: frame f phase p of the current job is cycle job_s+3+4f+p.
    // The result for word k is only present at phase 3 of frame k+1; every
    // other phase carries a junk value so a mistimed sample is visible.
    initial begin : mac_drv
        int d;
        forever begin
            @(posedge clk);
            #1;
            d = cyc - (job_s + 3);
            if (d < 0)
                mac_acc = '0;
            else if ((d % 4 == 3) && (d / 4 >= 1) && (d / 4 <= 8))
                mac_acc = cap_val[d / 4 - 1];
            else
                mac_acc = 20'h0BAD0 + 20'(d % 4);
        end
    end

    // Passive monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (ram_en) addr_q.push_back({22'd0, ram_addr});
        if (busy) word_q.push_back({inputattr, inputcoeff});
        if (res_valid && res_ready) begin
            acc_q.push_back({12'd0, res_data});
            last_acc_cyc = cyc;
        end
        if (res_valid && !prev_valid) valid_rise++;
        prev_valid = res_valid;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
        addr_q.delete();
        acc_q.delete();
        word_q.delete();
        valid_rise = 0;
        done_cnt   = 0;
        base_addr  = b;
        n_words    = n;
        start      = 1'b1;
        job_s      = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        check_val({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ram_en"},    {31'd0, ram_en},     32'd0);
        check_val({tag, "_ram_addr"},  {22'd0, ram_addr},   32'd0);
        check_val({tag, "_attr"},      {8'd0, inputattr},   32'd0);
        check_val({tag, "_coeff"},     {8'd0, inputcoeff},  32'd0);
        check_val({tag, "_res_data"},  {12'd0, res_data},   32'd0);
        check_val({tag, "_res_valid"}, {31'd0, res_valid},  32'd0);
        check_val({tag, "_total"},     {4'd0, total},       32'd0);
        check_val({tag, "_busy"},      {31'd0, busy},       32'd0);
        check_val({tag, "_done"},      {31'd0, done},       32'd0);
        check_val({tag, "_overflow"},  {31'd0, overflow},   32'd0);
    endtask

    function automatic logic [31:0] q_at(input int which, input int i);
        if (which == 0) return (addr_q.size() > i) ? addr_q[i] : 32'hFFFF_FFFF;
        return (acc_q.size() > i) ? acc_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int count_word(input logic [47:0] w);
        int c = 0;
        foreach (word_q[i]) if (word_q[i] == w) c++;
        return c;
    endfunction

    initial begin
        int s;
        int dd;
        logic [AW-1:0] a;
        for (int i = 0; i < 8; i++) cap_val[i] = '0;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // ---------------- empty job ----------------
        start_job(10'h055, 10'd0);
        check_val("empty_done_pulse", {31'd0, done}, 32'd1);
        check_val("empty_busy",       {31'd0, busy}, 32'd0);
        tick();
        check_val("empty_done_low",   {31'd0, done}, 32'd0);
        repeat (4) tick();
        check_val("empty_done_count", done_cnt, 32'd1);
        check_val("empty_no_reads",   addr_q.size(), 32'd0);

        // ---------------- back-to-back handshake ----------------
        res_ready = 1'b1;
        cap_val[0] = 20'd100; cap_val[1] = 20'd200; cap_val[2] = 20'd300; cap_val[3] = 20'd400;
        start_job(10'h010, 10'd4);
        wait_done(60, "b2b");
        check_val("b2b_n_results", acc_q.size(), 32'd4);
        check_val("b2b_res0", q_at(1, 0), 32'd100);
        check_val("b2b_res1", q_at(1, 1), 32'd200);
        check_val("b2b_res2", q_at(1, 2), 32'd300);
        check_val("b2b_res3", q_at(1, 3), 32'd400);
        check_val("b2b_valid_pulses", valid_rise, 32'd4);
        check_val("b2b_total", {4'd0, total}, 32'd1000);
        check_val("b2b_overflow", {31'd0, overflow}, 32'd0);
        check_val("b2b_done_count", done_cnt, 32'd1);
        dd = done_cyc - last_acc_cyc;
        check_val("b2b_done_after_accept", {31'd0, (dd >= 1) && (dd <= 2)}, 32'd1);
        check_val("b2b_n_reads", addr_q.size(), 32'd4);
        check_val("b2b_last_addr", q_at(0, 3), 32'h013);

        // ---------------- address wrap / word hold time ----------------
        cap_val[0] = 20'd1; cap_val[1] = 20'd2; cap_val[2] = 20'd3;
        start_job(10'h3FE, 10'd3);
        wait_done(60, "wrap");
        check_val("wrap_n_reads", addr_q.size(), 32'd3);
        check_val("wrap_addr0", q_at(0, 0), 32'h3FE);
        check_val("wrap_addr1", q_at(0, 1), 32'h3FF);
        check_val("wrap_addr2", q_at(0, 2), 32'h000);
        for (int i = 0; i < 3; i++) begin
            a = 10'h3FE + 10'(i);
            check_val($sformatf("wrap_word%0d_cycles", i),
                      count_word({24'hA00000 | {14'd0, a}, 24'hC00000 | {14'd0, a}}), 32'd4);
        end
        check_val("wrap_total", {4'd0, total}, 32'd6);

        // ---------------- lost result ----------------
        res_ready = 1'b0;
        cap_val[0] = 20'd7; cap_val[1] = 20'd9;
        start_job(10'h020, 10'd2);
        s = job_s;
        wait_until(s + 12);
        check_val("lost_first_valid", {31'd0, res_valid}, 32'd1);
        check_val("lost_first_data",  {12'd0, res_data},  32'd7);
        check_val("lost_first_ovf",   {31'd0, overflow},  32'd0);
        wait_until(s + 20);
        check_val("lost_data",     {12'd0, res_data}, 32'd9);
        check_val("lost_overflow", {31'd0, overflow}, 32'd1);
        check_val("lost_total",    {4'd0, total},     32'd16);
        check_val("lost_busy",     {31'd0, busy},     32'd1);
        check_val("lost_no_done",  done_cnt,          32'd0);
        res_ready = 1'b1;
        wait_done(20, "lost");
        check_val("lost_n_accepted", acc_q.size(), 32'd1);
        check_val("lost_accepted",   q_at(1, 0),   32'd9);
        check_val("lost_ovf_sticky", {31'd0, overflow}, 32'd1);

        // ---------------- capture on accept cycle ----------------
        res_ready = 1'b0;
        cap_val[0] = 20'd11; cap_val[1] = 20'd22; cap_val[2] = 20'd33;
        start_job(10'h030, 10'd3);
        s = job_s;
        wait_until(s + 14);
        check_val("acc_ovf_cleared", {31'd0, overflow},  32'd0);
        check_val("acc_pending",     {12'd0, res_data},  32'd11);
        res_ready = 1'b1;
        wait_done(40, "acc");
        check_val("acc_n_results", acc_q.size(), 32'd3);
        check_val("acc_res0", q_at(1, 0), 32'd11);
        check_val("acc_res1", q_at(1, 1), 32'd22);
        check_val("acc_res2", q_at(1, 2), 32'd33);
        check_val("acc_overflow", {31'd0, overflow}, 32'd0);
        check_val("acc_total", {4'd0, total}, 32'd66);

        // ---------------- reset mid-stream ----------------
        res_ready = 1'b1;
        cap_val[0] = 20'h123; cap_val[1] = 20'h1; cap_val[2] = 20'h2;
        cap_val[3] = 20'h3;   cap_val[4] = 20'h4;
        start_job(10'h040, 10'd5);
        s = job_s;
        wait_until(s + 12);
        check_val("rst_pre_busy",  {31'd0, busy},     32'd1);
        check_val("rst_pre_word2", {8'd0, inputattr}, 32'hA00042);
        check_val("rst_pre_total", {4'd0, total},     32'h123);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        repeat (6) tick();
        check_val("rst_no_done", done_cnt, 32'd0);
        check_val("rst_idle",    {31'd0, busy}, 32'd0);
        cap_val[0] = 20'd5; cap_val[1] = 20'd6;
        start_job(10'h200, 10'd2);
        wait_done(40, "rst_restart");
        check_val("rst_restart_addr0", q_at(0, 0), 32'h200);
        check_val("rst_restart_addr1", q_at(0, 1), 32'h201);
        check_val("rst_restart_res0",  q_at(1, 0), 32'd5);
        check_val("rst_restart_res1",  q_at(1, 1), 32'd6);
        check_val("rst_restart_total", {4'd0, total}, 32'd11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
